grant_decoder_3x8: RTL and testbench

- Registered 3-to-8 decoder and the partner of the team's 8x3 priority encoder. It accepts a 3-bit index from the encoder path over a valid/ready handshake.
- It drives the matching one-hot grant line for a programmable number of cycles, then forces a quiet gap before accepting the next index.
- It sits between the request arbiter and the eight downstream consumers.

---
 rtl/grant_decoder_3x8.sv | 89 ++++++++
 tb/tb_grant_decoder_3x8.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grant_decoder_3x8.sv
// Registered 3-to-8 grant decoder: one-hot D one edge after accept, held max(hold,1) cycles,
// then a GAP_CYCLES quiet gap; ready drops outside IDLE or when en is low, so valid simply waits.
module grant_decoder_3x8 #(
  parameter int HOLD_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              valid,
  output logic              ready,
  input  logic [2:0]        code,
  input  logic [HOLD_W-1:0] hold,
  output logic [7:0]        D,
  output logic              busy,
  output logic              done
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  assign ready = en && (state == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      D        <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid && ready) begin
            D        <= 8'b0000_0001 << code;
            busy     <= 1'b1;
            hold_cnt <= (hold == '0) ? HOLD_W'(1) : hold;
            state    <= S_GRANT;
          end
        end

        S_GRANT: begin
          // Abort wins over a coinciding last cycle, so an aborted grant never pulses done.
          if (!en || hold_cnt == HOLD_W'(1)) begin
            D    <= 8'h00;
            done <= en;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          D     <= 8'h00;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_decoder_3x8.sv
// Directed bench for grant_decoder_3x8 (HOLD_W=4, GAP_CYCLES=1); inputs driven and outputs sampled on negedge.
module tb_grant_decoder_3x8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       valid;
  logic       ready;
  logic [2:0] code;
  logic [3:0] hold;
  logic [7:0] D;
  logic       busy;
  logic       done;

  int total;
  int bad;

  grant_decoder_3x8 #(.HOLD_W(4), .GAP_CYCLES(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .valid (valid),
    .ready (ready),
    .code  (code),
    .hold  (hold),
    .D     (D),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; valid = 1'b0; code = 3'd0; hold = 4'd0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (D !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_held got D=%h busy=%b done=%b exp D=00 busy=0 done=0", D, busy, done);
    end
    rst = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1 || D !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got ready=%b D=%h busy=%b done=%b exp ready=1 D=00 busy=0 done=0",
               ready, D, busy, done);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    code = 3'd2; hold = 4'd3; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid = 1'b0;
      total++;
      if (D !== 8'b0000_0100 || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL basic_grant%0d got D=%h busy=%b ready=%b done=%b exp D=04 busy=1 ready=0 done=0",
                 i, D, busy, ready, done);
      end
    end
    @(negedge clk);
    total++;
    if (D !== 8'h00 || done !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_done got D=%h done=%b busy=%b ready=%b exp D=00 done=1 busy=1 ready=0",
               D, done, busy, ready);
    end
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || D !== 8'h00) begin
      bad++;
      $display("FAIL basic_idle got ready=%b busy=%b done=%b D=%h exp ready=1 busy=0 done=0 D=00",
               ready, busy, done, D);
    end
  endtask

  task automatic test_sweep;
    int idx;
    int dones;
    logic exp_rdy;
    logic [7:0] exp_d;
    idx = 0; dones = 0;
    code = 3'd0; hold = 4'd0; valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      exp_rdy = (idx < 8) && (c % 3 == 0);
      if (idx < 8) begin
        total++;
        if (ready !== exp_rdy) begin
          bad++;
          $display("FAIL sweep_ready c=%0d got=%b exp=%b", c, ready, exp_rdy);
        end
      end
      @(negedge clk);
      exp_d = exp_rdy ? (8'b0000_0001 << code) : 8'h00;
      total++;
      if (D !== exp_d) begin
        bad++;
        $display("FAIL sweep_d c=%0d got=%h exp=%h", c, D, exp_d);
      end
      if (done === 1'b1) dones++;
      if (exp_rdy) begin
        idx++;
        if (idx == 8) valid = 1'b0;
        else code = 3'(idx);
      end
    end
    total++;
    if (dones != 8) begin
      bad++;
      $display("FAIL sweep_done_count got=%0d exp=8", dones);
    end
  endtask

  task automatic test_abort;
    code = 3'd7; hold = 4'd10; valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid = 1'b0;
      total++;
      if (D !== 8'h80 || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_grant%0d got D=%h done=%b exp D=80 done=0", i, D, done);
      end
      if (i == 3) en = 1'b0;
    end
    @(negedge clk);
    total++;
    if (D !== 8'h00 || done !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_gap got D=%h done=%b busy=%b ready=%b exp D=00 done=0 busy=1 ready=0",
               D, done, busy, ready);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (D !== 8'h00 || done !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
        bad++;
        $display("FAIL abort_en_low%0d got D=%h done=%b busy=%b ready=%b exp D=00 done=0 busy=0 ready=0",
                 i, D, done, busy, ready);
      end
    end
    en = 1'b1;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_reenable got ready=%b exp=1", ready);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    code = 3'd5; hold = 4'd8; valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid = 1'b0;
      total++;
      if (D !== 8'h20) begin
        bad++;
        $display("FAIL areset_grant%0d got D=%h exp D=20", i, D);
      end
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (D !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate got D=%h busy=%b done=%b exp D=00 busy=0 done=0", D, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (ready !== 1'b1 || busy !== 1'b0 || D !== 8'h00) begin
      bad++;
      $display("FAIL areset_idle got ready=%b busy=%b D=%h exp ready=1 busy=0 D=00", ready, busy, D);
    end
    code = 3'd3; hold = 4'd1; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (D !== 8'h08) begin
      bad++;
      $display("FAIL areset_reaccept got D=%h exp D=08", D);
    end
    @(negedge clk);
    total++;
    if (D !== 8'h00 || done !== 1'b1) begin
      bad++;
      $display("FAIL areset_done got D=%h done=%b exp D=00 done=1", D, done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    code = 3'd0; hold = 4'd1; valid = 1'b1;
    @(negedge clk);
    code = 3'd1;
    total++;
    if (D !== 8'h01) begin
      bad++;
      $display("FAIL b2b_first got D=%h exp D=01", D);
    end
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || busy !== 1'b1 || done !== 1'b1 || D !== 8'h00) begin
      bad++;
      $display("FAIL b2b_gap got ready=%b busy=%b done=%b D=%h exp ready=0 busy=1 done=1 D=00",
               ready, busy, done, D);
    end
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || D !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_post_gap got ready=%b D=%h busy=%b exp ready=1 D=00 busy=0", ready, D, busy);
    end
    @(negedge clk);
    valid = 1'b0;
    total++;
    if (D !== 8'b0000_0010) begin
      bad++;
      $display("FAIL b2b_second got D=%h exp D=02", D);
    end
    @(negedge clk);
    total++;
    if (D !== 8'h00 || done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second_done got D=%h done=%b exp D=00 done=1", D, done);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (D !== 8'h00 || busy !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_dup got D=%h busy=%b ready=%b exp D=00 busy=0 ready=1", D, busy, ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_sweep();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
